wb_interconnect_arb: RTL and testbench

WB_INTERCONNECT_ARB -- requirements
Module: wb_interconnect_arb

---
 rtl/wb_interconnect_arb_if.sv | 49 ++++
 rtl/wb_interconnect_arb.sv | 183 ++++++++++++++++++
 tb/tb_wb_interconnect_arb.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_interconnect_arb_if.sv
// Wishbone pipelined bundle between NM masters, the interconnect and NS slaves.
// The slave modport is the interconnect's view; the master modport is the view
// of the surrounding agents (the bus masters and the addressed slaves).
interface wb_interconnect_arb_if #(
  parameter int NM = 2,
  parameter int NS = 2,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [NM-1:0]        m_cyc;
  logic [NM-1:0]        m_stb;
  logic [NM-1:0]        m_we;
  logic [NM*DW/8-1:0]   m_sel;
  logic [NM*AW-1:0]     m_adr;
  logic [NM*DW-1:0]     m_dat_w;
  logic [DW-1:0]        m_dat_r;
  logic [NM-1:0]        m_ack;
  logic [NM-1:0]        m_err;
  logic [NM-1:0]        m_stall;

  logic [NS-1:0]        s_cyc;
  logic [NS-1:0]        s_stb;
  logic                 s_we;
  logic [DW/8-1:0]      s_sel;
  logic [AW-1:0]        s_adr;
  logic [DW-1:0]        s_dat_w;
  logic [NS*DW-1:0]     s_dat_r;
  logic [NS-1:0]        s_ack;
  logic [NS-1:0]        s_err;
  logic [NS-1:0]        s_stall;

  logic [NM-1:0]        grant;

  modport slave (
    input  m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_w,
    output m_dat_r, m_ack, m_err, m_stall,
    output s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w,
    input  s_dat_r, s_ack, s_err, s_stall,
    output grant
  );

  modport master (
    output m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_w,
    input  m_dat_r, m_ack, m_err, m_stall,
    input  s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w,
    output s_dat_r, s_ack, s_err, s_stall,
    input  grant
  );
endinterface

// File: rtl/wb_interconnect_arb.sv
// Shared-bus Wishbone pipelined interconnect: round-robin arbitration between
// NM masters, address decode to NS slaves, outstanding-request tracking with a
// single target at a time, internal error for unmapped addresses and a
// response timeout that aborts the owner's cycle.
module wb_interconnect_arb #(
  parameter int NM      = 2,
  parameter int NS      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAXOUT  = 4,
  parameter int TIMEOUT = 255,
  parameter logic [AW-1:0] BASE_ADDR [NS] = '{32'h0000_0000, 32'h0001_0000},
  parameter logic [AW-1:0] SIZE      [NS] = '{32'h0001_0000, 32'h0000_1000}
) (
  input  logic clk,
  input  logic rst,
  wb_interconnect_arb_if.slave bus
);

  localparam int MW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW = $clog2(MAXOUT + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t          state, state_nx;
  logic [MW-1:0]   owner;
  logic [MW-1:0]   ptr;
  logic [MW-1:0]   win_idx;
  logic [MW-1:0]   cand;
  logic            win_vld;
  logic [CW-1:0]   out_cnt;
  logic            tgt_none;
  logic [SW-1:0]   tgt_idx;
  logic            err_pend;
  logic [TW-1:0]   tmo_cnt;

  logic            own_cyc, own_stb, own_we;
  logic [DW/8-1:0] own_sel;
  logic [AW-1:0]   own_adr;
  logic [DW-1:0]   own_dat_w;
  logic            dec_hit;
  logic [SW-1:0]   dec_idx;
  logic            full, busy_out, tgt_diff, slv_stall, own_stall;
  logic            live, accept, resp_ack, resp_err, resp, tmo_hit;

  // Address decode: {hit, index}; the downward scan lets the lowest index win on overlap.
  function automatic logic [SW:0] decode(input logic [AW-1:0] adr);
    logic [AW:0] a, lo, hi;
    logic [SW:0] r;
    r = '0;
    a = {1'b0, adr};
    for (int i = NS - 1; i >= 0; i--) begin
      lo = {1'b0, BASE_ADDR[i]};
      hi = lo + {1'b0, SIZE[i]};
      if (a >= lo && a < hi) r = {1'b1, SW'(i)};
    end
    return r;
  endfunction

  // Outstanding count update; a simultaneous accept and response cancel out.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic inc,
                                              input logic dec);
    case ({inc, dec})
      2'b10:   return c + 1'b1;
      2'b01:   return c - 1'b1;
      default: return c;
    endcase
  endfunction

  assign own_cyc   = bus.m_cyc[owner];
  assign own_stb   = bus.m_stb[owner];
  assign own_we    = bus.m_we[owner];
  assign own_sel   = bus.m_sel[owner*(DW/8) +: DW/8];
  assign own_adr   = bus.m_adr[owner*AW +: AW];
  assign own_dat_w = bus.m_dat_w[owner*DW +: DW];

  assign {dec_hit, dec_idx} = decode(own_adr);

  assign full      = (out_cnt == CW'(MAXOUT));
  assign busy_out  = (out_cnt != '0);
  // A request may only go to the target that already has requests in flight.
  assign tgt_diff  = busy_out && ((dec_hit == tgt_none) || (dec_hit && dec_idx != tgt_idx));
  assign slv_stall = dec_hit && bus.s_stall[dec_idx];
  assign own_stall = full || tgt_diff || slv_stall;
  assign live      = (state == BUSY) && own_cyc;
  assign accept    = live && own_stb && !own_stall;
  assign resp_ack  = live && busy_out && !tgt_none && bus.s_ack[tgt_idx];
  assign resp_err  = live && busy_out && (tgt_none ? err_pend : bus.s_err[tgt_idx]);
  assign resp      = resp_ack || resp_err;
  assign tmo_hit   = (TIMEOUT != 0) && live && busy_out && !resp &&
                     (tmo_cnt == TW'(TIMEOUT - 1));

  assign bus.grant = (state == IDLE) ? '0 : (NM'(1) << owner);

  // Round-robin search starting at the pointer; lower offsets from the pointer win.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    cand    = ptr;
    for (int k = NM - 1; k >= 0; k--) begin
      cand = MW'((int'(ptr) + k) % NM);
      if (bus.m_cyc[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next state and all bus outputs; without an owner every master sees stall.
  always_comb begin
    state_nx    = state;
    bus.s_cyc   = '0;
    bus.s_stb   = '0;
    bus.s_we    = 1'b0;
    bus.s_sel   = '0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    bus.m_stall = '1;
    bus.m_dat_r = '0;
    case (state)
      IDLE: begin
        if (win_vld) state_nx = BUSY;
      end
      BUSY: begin
        if (!own_cyc)     state_nx = IDLE;
        else if (tmo_hit) state_nx = ABORT;
        bus.s_cyc   = {NS{own_cyc}};
        bus.s_we    = own_we;
        bus.s_sel   = own_sel;
        bus.s_adr   = own_adr;
        bus.s_dat_w = own_dat_w;
        if (own_cyc && own_stb && dec_hit && !full && !tgt_diff) bus.s_stb[dec_idx] = 1'b1;
        bus.m_stall[owner] = own_stall;
        bus.m_ack[owner]   = resp_ack;
        bus.m_err[owner]   = resp_err || tmo_hit;
        if (resp && !tgt_none) bus.m_dat_r = bus.s_dat_r[tgt_idx*DW +: DW];
      end
      ABORT: begin
        if (!own_cyc) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, ownership and request tracking; anything in flight is dropped outside BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      out_cnt  <= '0;
      tgt_none <= 1'b1;
      tgt_idx  <= '0;
      err_pend <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && win_vld) begin
        owner <= win_idx;
        ptr   <= (win_idx == MW'(NM - 1)) ? '0 : win_idx + 1'b1;
      end
      if (state != BUSY || !own_cyc || tmo_hit) begin
        out_cnt  <= '0;
        tgt_none <= 1'b1;
        err_pend <= 1'b0;
        tmo_cnt  <= '0;
      end else begin
        out_cnt <= cnt_next(out_cnt, accept, resp);
        if (accept) begin
          tgt_none <= !dec_hit;
          tgt_idx  <= dec_idx;
        end
        err_pend <= accept && !dec_hit;
        tmo_cnt  <= (resp || !busy_out) ? '0 : tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_interconnect_arb.sv
// Directed bench for wb_interconnect_arb with two masters, two slaves and an
// eight-cycle response timeout. Inputs change on the falling edge; outputs are
// sampled 1 ns later.
module tb_wb_interconnect_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_interconnect_arb_if #(.NM(2), .NS(2), .AW(32), .DW(32)) bus ();

  wb_interconnect_arb #(.NM(2), .NS(2), .AW(32), .DW(32), .MAXOUT(4), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0; bus.m_sel = '0;
    bus.m_adr = '0; bus.m_dat_w = '0;
    bus.s_dat_r = '0; bus.s_ack = '0; bus.s_err = '0; bus.s_stall = '0;
  endtask

  task automatic apply_reset();
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc[0] = cyc; bus.m_stb[0] = stb; bus.m_we[0] = we;
    bus.m_sel[3:0] = 4'hF; bus.m_adr[31:0] = adr; bus.m_dat_w[31:0] = dat;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.m_cyc = 2'b11;
    bus.s_ack = 2'b11;
    tick();
    #1;
    n_chk++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", bus.grant); end
    n_chk++; if (bus.s_cyc !== 2'b00) begin n_fail++; $display("FAIL rst_s_cyc: got %b want 00", bus.s_cyc); end
    n_chk++; if (bus.s_stb !== 2'b00) begin n_fail++; $display("FAIL rst_s_stb: got %b want 00", bus.s_stb); end
    n_chk++; if (bus.m_ack !== 2'b00) begin n_fail++; $display("FAIL rst_m_ack: got %b want 00", bus.m_ack); end
    n_chk++; if (bus.m_err !== 2'b00) begin n_fail++; $display("FAIL rst_m_err: got %b want 00", bus.m_err); end
    n_chk++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("FAIL rst_m_stall: got %b want 11", bus.m_stall); end
    n_chk++; if (bus.m_dat_r !== 32'h0) begin n_fail++; $display("FAIL rst_m_dat_r: got %h want 0", bus.m_dat_r); end
  endtask

  task automatic test_write();
    apply_reset();
    set_m0(1, 1, 1, 32'h10, 32'hDEADBEEF);
    #1;
    n_chk++; if (bus.s_stb !== 2'b00) begin n_fail++; $display("FAIL wr_idle_stb: got %b want 00", bus.s_stb); end
    tick();
    #1;
    n_chk++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL wr_grant: got %b want 01", bus.grant); end
    n_chk++; if (bus.s_stb !== 2'b01) begin n_fail++; $display("FAIL wr_s_stb: got %b want 01", bus.s_stb); end
    n_chk++; if (bus.s_dat_w !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_s_dat_w: got %h want deadbeef", bus.s_dat_w); end
    n_chk++; if ({bus.s_we, bus.s_sel, bus.s_adr} !== {1'b1, 4'hF, 32'h10}) begin n_fail++; $display("FAIL wr_s_ctl: got %b %h %h want 1 f 10", bus.s_we, bus.s_sel, bus.s_adr); end
    n_chk++; if (bus.m_stall !== 2'b10) begin n_fail++; $display("FAIL wr_m_stall: got %b want 10", bus.m_stall); end
    tick();
    bus.m_stb[0] = 1'b0;
    bus.s_ack[0] = 1'b1;
    #1;
    n_chk++; if (bus.s_stb !== 2'b00) begin n_fail++; $display("FAIL wr_stb_once: got %b want 00", bus.s_stb); end
    n_chk++; if (bus.m_ack !== 2'b01) begin n_fail++; $display("FAIL wr_m_ack: got %b want 01", bus.m_ack); end
    tick();
    bus.s_ack[0] = 1'b0;
    #1;
    n_chk++; if (bus.m_ack !== 2'b00) begin n_fail++; $display("FAIL wr_ack_once: got %b want 00", bus.m_ack); end
    bus.m_cyc[0] = 1'b0;
    tick();
    #1;
    n_chk++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL wr_release: got %b want 00", bus.grant); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.m_cyc = 2'b11;
    tick();
    #1;
    n_chk++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL rr_first: got %b want 01", bus.grant); end
    n_chk++; if (bus.m_stall !== 2'b10) begin n_fail++; $display("FAIL rr_nonowner_stall: got %b want 10", bus.m_stall); end
    tick();
    bus.m_cyc = 2'b10;
    #1;
    n_chk++; if (bus.s_cyc !== 2'b00) begin n_fail++; $display("FAIL rr_drop_s_cyc: got %b want 00", bus.s_cyc); end
    tick();
    #1;
    n_chk++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL rr_idle: got %b want 00", bus.grant); end
    tick();
    bus.m_cyc = 2'b11;
    #1;
    n_chk++; if (bus.grant !== 2'b10) begin n_fail++; $display("FAIL rr_second: got %b want 10", bus.grant); end
    n_chk++; if (bus.m_stall !== 2'b01) begin n_fail++; $display("FAIL rr_m1_stall: got %b want 01", bus.m_stall); end
    tick();
    bus.m_cyc = 2'b01;
    tick();
    bus.m_cyc = 2'b11;
    #1;
    n_chk++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL rr_idle2: got %b want 00", bus.grant); end
    tick();
    #1;
    n_chk++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL rr_wrap: got %b want 01", bus.grant); end
    bus.m_cyc = 2'b00;
  endtask

  task automatic test_unmapped();
    apply_reset();
    set_m0(1, 1, 0, 32'h0002_0000, 32'h0);
    tick();
    #1;
    n_chk++; if (bus.s_stb !== 2'b00) begin n_fail++; $display("FAIL um_s_stb: got %b want 00", bus.s_stb); end
    n_chk++; if (bus.m_stall[0] !== 1'b0) begin n_fail++; $display("FAIL um_accept: got %b want 0", bus.m_stall[0]); end
    tick();
    bus.m_stb[0] = 1'b0;
    #1;
    n_chk++; if (bus.m_err !== 2'b01) begin n_fail++; $display("FAIL um_m_err: got %b want 01", bus.m_err); end
    n_chk++; if (bus.m_dat_r !== 32'h0) begin n_fail++; $display("FAIL um_dat: got %h want 0", bus.m_dat_r); end
    tick();
    set_m0(1, 1, 0, 32'h10, 32'h0);
    #1;
    n_chk++; if (bus.m_err !== 2'b00) begin n_fail++; $display("FAIL um_err_once: got %b want 00", bus.m_err); end
    n_chk++; if (bus.s_stb !== 2'b01) begin n_fail++; $display("FAIL um_cnt_zero: got %b want 01", bus.s_stb); end
    tick();
    clear_inputs();
  endtask

  task automatic test_decode();
    logic [31:0] adr_t [6] = '{32'h0, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_0FFF,
                               32'h0001_1000, 32'hFFFF_FFFF};
    logic [1:0]  stb_t [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    logic        stl_t [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    bus.s_stall = 2'b11;
    set_m0(1, 1, 0, adr_t[0], 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.m_adr[31:0] = adr_t[i];
      #1;
      n_chk++; if (bus.s_stb !== stb_t[i]) begin n_fail++; $display("FAIL dec_stb[%0d]: got %b want %b", i, bus.s_stb, stb_t[i]); end
      n_chk++; if (bus.m_stall[0] !== stl_t[i]) begin n_fail++; $display("FAIL dec_stall[%0d]: got %b want %b", i, bus.m_stall[0], stl_t[i]); end
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic        stb_t [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] adr_t [10] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                                32'h110, 32'h110, 32'h110, 32'h110, 32'h110};
    logic        ack_t [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1};
    logic [31:0] dat_t [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA0,
                                32'hA1, 32'hA2, 32'hA3, 32'h0, 32'hA4};
    logic        stl_t [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    apply_reset();
    set_m0(1, 1, 0, adr_t[0], 32'h0);
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.m_stb[0] = stb_t[k];
      bus.m_adr[31:0] = adr_t[k];
      bus.s_ack[0] = ack_t[k];
      if (ack_t[k]) bus.s_dat_r[31:0] = dat_t[k];
      #1;
      if (stb_t[k]) begin
        n_chk++; if (bus.m_stall[0] !== stl_t[k]) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %b want %b", k, bus.m_stall[0], stl_t[k]); end
        n_chk++; if (bus.s_stb[0] !== !stl_t[k]) begin n_fail++; $display("FAIL b2b_stb[%0d]: got %b want %b", k, bus.s_stb[0], !stl_t[k]); end
      end
      n_chk++; if (bus.m_ack[0] !== ack_t[k]) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b want %b", k, bus.m_ack[0], ack_t[k]); end
      n_chk++; if (bus.m_dat_r !== dat_t[k]) begin n_fail++; $display("FAIL b2b_dat[%0d]: got %h want %h", k, bus.m_dat_r, dat_t[k]); end
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_target_switch();
    apply_reset();
    set_m0(1, 1, 0, 32'h0, 32'h0);
    tick();
    #1;
    n_chk++; if (bus.s_stb !== 2'b01) begin n_fail++; $display("FAIL ts_s0_stb: got %b want 01", bus.s_stb); end
    tick();
    bus.m_adr[31:0] = 32'h0001_0004;
    #1;
    n_chk++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("FAIL ts_hold: got %b want 11", bus.m_stall); end
    n_chk++; if (bus.s_stb !== 2'b00) begin n_fail++; $display("FAIL ts_hold_stb: got %b want 00", bus.s_stb); end
    tick();
    bus.s_ack[0] = 1'b1;
    bus.s_dat_r = {32'h0000_0051, 32'h0000_0050};
    #1;
    n_chk++; if (bus.m_stall[0] !== 1'b1) begin n_fail++; $display("FAIL ts_hold_ack: got %b want 1", bus.m_stall[0]); end
    n_chk++; if (bus.m_dat_r !== 32'h50) begin n_fail++; $display("FAIL ts_s0_dat: got %h want 50", bus.m_dat_r); end
    tick();
    bus.s_ack[0] = 1'b0;
    #1;
    n_chk++; if (bus.s_stb !== 2'b10) begin n_fail++; $display("FAIL ts_s1_stb: got %b want 10", bus.s_stb); end
    tick();
    bus.m_stb[0] = 1'b0;
    bus.s_ack[0] = 1'b1;
    #1;
    n_chk++; if (bus.m_ack !== 2'b00) begin n_fail++; $display("FAIL ts_foreign_ack: got %b want 00", bus.m_ack); end
    tick();
    bus.s_ack = 2'b10;
    #1;
    n_chk++; if (bus.m_ack !== 2'b01) begin n_fail++; $display("FAIL ts_s1_ack: got %b want 01", bus.m_ack); end
    n_chk++; if (bus.m_dat_r !== 32'h51) begin n_fail++; $display("FAIL ts_s1_dat: got %h want 51", bus.m_dat_r); end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout_reset();
    logic exp_err;
    apply_reset();
    set_m0(1, 1, 0, 32'h20, 32'h0);
    tick();
    #1;
    n_chk++; if (bus.m_stall[0] !== 1'b0) begin n_fail++; $display("FAIL to_accept: got %b want 0", bus.m_stall[0]); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      bus.m_stb[0] = 1'b0;
      exp_err = (k == 8);
      #1;
      n_chk++; if (bus.m_err[0] !== exp_err) begin n_fail++; $display("FAIL to_err[%0d]: got %b want %b", k, bus.m_err[0], exp_err); end
      n_chk++; if (bus.s_cyc !== 2'b11) begin n_fail++; $display("FAIL to_s_cyc[%0d]: got %b want 11", k, bus.s_cyc); end
    end
    tick();
    bus.s_ack[0] = 1'b1;
    #1;
    n_chk++; if (bus.s_cyc !== 2'b00) begin n_fail++; $display("FAIL ab_s_cyc: got %b want 00", bus.s_cyc); end
    n_chk++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("FAIL ab_stall: got %b want 11", bus.m_stall); end
    n_chk++; if ({bus.m_ack, bus.m_err} !== 4'b0000) begin n_fail++; $display("FAIL ab_resp: got %b want 0000", {bus.m_ack, bus.m_err}); end
    n_chk++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL ab_grant: got %b want 01", bus.grant); end
    tick();
    rst = 1'b1;
    bus.m_cyc = 2'b11;
    tick();
    #1;
    n_chk++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL mr_grant: got %b want 00", bus.grant); end
    n_chk++; if ({bus.s_cyc, bus.s_stb} !== 4'b0000) begin n_fail++; $display("FAIL mr_slave: got %b want 0000", {bus.s_cyc, bus.s_stb}); end
    n_chk++; if ({bus.m_ack, bus.m_err} !== 4'b0000) begin n_fail++; $display("FAIL mr_resp: got %b want 0000", {bus.m_ack, bus.m_err}); end
    n_chk++; if (bus.m_stall !== 2'b11) begin n_fail++; $display("FAIL mr_stall: got %b want 11", bus.m_stall); end
    n_chk++; if (bus.m_dat_r !== 32'h0) begin n_fail++; $display("FAIL mr_dat: got %h want 0", bus.m_dat_r); end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_unmapped();
    test_decode();
    test_back_to_back();
    test_target_switch();
    test_timeout_reset();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, want end of test");
    $fatal(1);
  end

endmodule
